// File: rtl/spu_ma_ldseq_if.sv
// Bus bundle between the MA load sequencer and its neighbours
// (MA control, spu_wen/LSU path, MA memory writer).
// The master modport is the sequencer itself; the slave modport is the environment.
interface spu_ma_ldseq_if #(
    parameter int LEN_W = 8
);
    // Start/kill controls from MA control
    logic             spu_mactl_ldop;
    logic [35:0]      spu_mactl_ld_pa;
    logic [LEN_W-1:0] spu_mactl_ld_len;
    logic             spu_mactl_kill;

    // Return path from spu_wen / LSU and the MA memory writer
    logic             spu_wen_mald_ack;
    logic             spu_wen_vld_maln;
    logic             spu_wen_ma_unc_err_pulse;
    logic             spu_mamem_wr_done;

    // Sequencer outputs
    logic             spu_mald_ldreq;
    logic [35:0]      spu_mald_pa;
    logic             spu_mald_line_vld;
    logic [LEN_W-1:0] spu_mald_line_idx;
    logic             spu_mald_rstln;
    logic             spu_mald_done;
    logic             spu_mald_busy;
    logic             spu_mald_err;

    modport master (
        input  spu_mactl_ldop, spu_mactl_ld_pa, spu_mactl_ld_len, spu_mactl_kill,
               spu_wen_mald_ack, spu_wen_vld_maln, spu_wen_ma_unc_err_pulse,
               spu_mamem_wr_done,
        output spu_mald_ldreq, spu_mald_pa, spu_mald_line_vld, spu_mald_line_idx,
               spu_mald_rstln, spu_mald_done, spu_mald_busy, spu_mald_err
    );

    modport slave (
        output spu_mactl_ldop, spu_mactl_ld_pa, spu_mactl_ld_len, spu_mactl_kill,
               spu_wen_mald_ack, spu_wen_vld_maln, spu_wen_ma_unc_err_pulse,
               spu_mamem_wr_done,
        input  spu_mald_ldreq, spu_mald_pa, spu_mald_line_vld, spu_mald_line_idx,
               spu_mald_rstln, spu_mald_done, spu_mald_busy, spu_mald_err
    );
endinterface

// File: rtl/spu_ma_ldseq.sv
// MA load sequencer: walks a run of 16-byte lines, issuing one load per line,
// handing each returned line to the MA memory writer, then pulsing line-reset.
// A kill or (optionally) an uncorrectable error lets the in-flight line finish
// and then ends the run with done.
// Optional feature macro: SPU_MALD_ERR_ABORT_EN -- when defined, an
// uncorrectable error also aborts the run after the erroring line.
module spu_ma_ldseq #(
    parameter int LEN_W = 8
) (
    input  logic                 rclk,
    input  logic                 arst_l,
    spu_ma_ldseq_if.master       bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ       = 3'd1,
        WAIT_DATA = 3'd2,
        WRITE     = 3'd3,
        RSTLN     = 3'd4,
        DONE      = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [35:0]      pa_q, pa_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             abort_q, abort_d;

    // State and datapath registers; everything clears asynchronously so the
    // request/valid outputs drop as soon as reset is asserted.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q <= IDLE;
            pa_q    <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pa_q    <= pa_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end

    // Next-state and counter update; a kill seen in RSTLN itself also ends the
    // run so the line that just finished is the last one.
    always_comb begin
        state_d = state_q;
        pa_d    = pa_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        err_d   = err_q;
        abort_d = abort_q;

        if (bus.spu_mactl_kill && (state_q != IDLE)) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.spu_mactl_ldop) begin
                    pa_d    = bus.spu_mactl_ld_pa;
                    idx_d   = '0;
                    rem_d   = bus.spu_mactl_ld_len;
                    err_d   = 1'b0;
                    abort_d = 1'b0;
                    state_d = (bus.spu_mactl_ld_len == '0) ? DONE : REQ;
                end
            end
            REQ: begin
                if (bus.spu_wen_mald_ack) begin
                    state_d = WAIT_DATA;
                end
            end
            WAIT_DATA, WRITE: begin
                if (bus.spu_wen_ma_unc_err_pulse) begin
                    err_d = 1'b1;
`ifdef SPU_MALD_ERR_ABORT_EN
                    abort_d = 1'b1;
`else
                    abort_d = abort_d;
`endif
                end
                if ((state_q == WAIT_DATA) && bus.spu_wen_vld_maln) begin
                    state_d = WRITE;
                end else if ((state_q == WRITE) && bus.spu_mamem_wr_done) begin
                    state_d = RSTLN;
                end
            end
            RSTLN: begin
                pa_d  = pa_q + 36'd1;
                idx_d = idx_q + LEN_W'(1);
                rem_d = rem_q - LEN_W'(1);
                if ((rem_q <= LEN_W'(1)) || abort_q || bus.spu_mactl_kill) begin
                    state_d = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registers
    assign bus.spu_mald_ldreq    = (state_q == REQ);
    assign bus.spu_mald_line_vld = (state_q == WRITE);
    assign bus.spu_mald_rstln    = (state_q == RSTLN);
    assign bus.spu_mald_done     = (state_q == DONE);
    assign bus.spu_mald_busy     = (state_q != IDLE);
    assign bus.spu_mald_pa       = pa_q;
    assign bus.spu_mald_line_idx = idx_q;
    assign bus.spu_mald_err      = err_q;

endmodule

// File: tb/tb_spu_ma_ldseq.sv
// Testbench for spu_ma_ldseq: plays the MA control, LSU/spu_wen and MA memory
// writer roles with randomized response delays, and compares the sequencer's
// behaviour against expectations computed from the run parameters.
module tb_spu_ma_ldseq;

    localparam int LEN_W = 8;

    logic rclk;
    logic arst_l;

    int compared   = 0;
    int mismatched = 0;
    int reqCnt     = 0;
    int rstCnt     = 0;
    int doneCnt    = 0;

    spu_ma_ldseq_if #(.LEN_W(LEN_W)) bus ();

    spu_ma_ldseq #(.LEN_W(LEN_W)) dut (
        .rclk   (rclk),
        .arst_l (arst_l),
        .bus    (bus)
    );

    // 10 ns clock
    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // Event counters for accepted requests, line resets and done pulses
    always @(posedge rclk) begin
        if (bus.spu_mald_ldreq && bus.spu_wen_mald_ack) reqCnt <= reqCnt + 1;
        if (bus.spu_mald_rstln) rstCnt <= rstCnt + 1;
        if (bus.spu_mald_done) doneCnt <= doneCnt + 1;
    end

    // Advance one clock and settle just after the edge
    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Single comparison point
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One complete run. killMode: 0 = kill in WAIT_DATA, 1 = kill with ack,
    // 2 = kill with wr_done; killLine/errLine of -1 means none.
    task automatic applyStimulus(input logic [35:0] startPa, input int len,
                                 input int killLine, input int killMode,
                                 input int errLine);
        int nExp, abortLine, reqBase, rstBase, doneBase, d;
        logic expErr;
        logic [35:0] expPa;

        // Reference: lines run until the length is exhausted or an abort
        // source fires, with the aborting line itself still completed.
        abortLine = len;
        if (killLine >= 0 && killLine < abortLine) abortLine = killLine;
`ifdef SPU_MALD_ERR_ABORT_EN
        if (errLine >= 0 && errLine < abortLine) abortLine = errLine;
`endif
        if (len == 0) nExp = 0;
        else if (abortLine < len) nExp = abortLine + 1;
        else nExp = len;
        expErr = (errLine >= 0) && (errLine < nExp);

        reqBase  = reqCnt;
        rstBase  = rstCnt;
        doneBase = doneCnt;

        bus.spu_mactl_ldop   = 1'b1;
        bus.spu_mactl_ld_pa  = startPa;
        bus.spu_mactl_ld_len = LEN_W'(len);
        tick();
        bus.spu_mactl_ldop   = 1'b0;
        bus.spu_mactl_ld_pa  = $urandom();
        bus.spu_mactl_ld_len = LEN_W'($urandom());
        checkOutput("busy_start", 64'(bus.spu_mald_busy), 64'd1);
        checkOutput("err_cleared", 64'(bus.spu_mald_err), 64'd0);

        for (int k = 0; k < nExp; k++) begin
            expPa = startPa + 36'(k);
            checkOutput($sformatf("ldreq_up_l%0d", k), 64'(bus.spu_mald_ldreq), 64'd1);
            checkOutput($sformatf("pa_l%0d", k), 64'(bus.spu_mald_pa), 64'(expPa));
            checkOutput($sformatf("idx_l%0d", k), 64'(bus.spu_mald_line_idx), 64'(k));

            d = $urandom_range(0, 3);
            repeat (d) tick();
            checkOutput($sformatf("ldreq_held_l%0d", k), 64'(bus.spu_mald_ldreq), 64'd1);
            bus.spu_wen_mald_ack = 1'b1;
            bus.spu_mactl_kill   = (killLine == k) && (killMode == 1);
            tick();
            bus.spu_wen_mald_ack = 1'b0;
            bus.spu_mactl_kill   = 1'b0;
            checkOutput($sformatf("ldreq_fall_l%0d", k), 64'(bus.spu_mald_ldreq), 64'd0);

            if (killLine == k && killMode == 0) begin
                bus.spu_mactl_kill = 1'b1;
                tick();
                bus.spu_mactl_kill = 1'b0;
            end
            d = $urandom_range(0, 3);
            repeat (d) tick();
            bus.spu_wen_vld_maln         = 1'b1;
            bus.spu_wen_ma_unc_err_pulse = (errLine == k);
            tick();
            bus.spu_wen_ma_unc_err_pulse = 1'b0;
            checkOutput($sformatf("line_vld_l%0d", k), 64'(bus.spu_mald_line_vld), 64'd1);

            d = $urandom_range(0, 3);
            repeat (d) tick();
            bus.spu_mamem_wr_done = 1'b1;
            bus.spu_mactl_kill    = (killLine == k) && (killMode == 2);
            tick();
            bus.spu_mamem_wr_done = 1'b0;
            bus.spu_mactl_kill    = 1'b0;
            checkOutput($sformatf("rstln_l%0d", k), 64'(bus.spu_mald_rstln), 64'd1);
            tick();
            bus.spu_wen_vld_maln = 1'b0;
        end

        checkOutput("done_pulse", 64'(bus.spu_mald_done), 64'd1);
        checkOutput("no_ldreq_in_done", 64'(bus.spu_mald_ldreq), 64'd0);
        tick();
        checkOutput("busy_fall", 64'(bus.spu_mald_busy), 64'd0);
        checkOutput("done_single", 64'(bus.spu_mald_done), 64'd0);
        checkOutput("req_count", 64'(reqCnt - reqBase), 64'(nExp));
        checkOutput("rstln_count", 64'(rstCnt - rstBase), 64'(nExp));
        checkOutput("done_count", 64'(doneCnt - doneBase), 64'd1);
        checkOutput("err_flag", 64'(bus.spu_mald_err), 64'(expErr));
    endtask

    // Directed sequence followed by randomized runs
    initial begin
        logic [35:0] rPa;
        int rLen, rKill, rErr;

        arst_l                       = 1'b0;
        bus.spu_mactl_ldop           = 1'b0;
        bus.spu_mactl_ld_pa          = '0;
        bus.spu_mactl_ld_len         = '0;
        bus.spu_mactl_kill           = 1'b0;
        bus.spu_wen_mald_ack         = 1'b0;
        bus.spu_wen_vld_maln         = 1'b0;
        bus.spu_wen_ma_unc_err_pulse = 1'b0;
        bus.spu_mamem_wr_done        = 1'b0;
        #1;
        checkOutput("rst_ldreq", 64'(bus.spu_mald_ldreq), 64'd0);
        checkOutput("rst_busy", 64'(bus.spu_mald_busy), 64'd0);
        checkOutput("rst_done", 64'(bus.spu_mald_done), 64'd0);
        checkOutput("rst_pa", 64'(bus.spu_mald_pa), 64'd0);
        checkOutput("rst_idx", 64'(bus.spu_mald_line_idx), 64'd0);
        checkOutput("rst_err", 64'(bus.spu_mald_err), 64'd0);
        #21 arst_l = 1'b1;
        tick();

        $display("[TB] basic run of 3 lines");
        applyStimulus(36'h0_0000_0100, 3, -1, 0, -1);
        $display("[TB] zero-length run");
        applyStimulus(36'h0_0000_0200, 0, -1, 0, -1);
        $display("[TB] PA wrap");
        applyStimulus(36'hF_FFFF_FFFF, 2, -1, 0, -1);
        $display("[TB] kill in WAIT_DATA of line 0");
        applyStimulus(36'h1_2345_6780, 5, 0, 0, -1);
        $display("[TB] uncorrectable error on line 1");
        applyStimulus(36'h0_0000_4000, 4, -1, 0, 1);
        $display("[TB] follow-up run clears err");
        applyStimulus(36'h0_0000_5000, 2, -1, 0, -1);
        $display("[TB] kill together with ack");
        applyStimulus(36'h0_0000_6000, 4, 1, 1, -1);
        $display("[TB] kill together with final wr_done");
        applyStimulus(36'h0_0000_7000, 3, 2, 2, -1);
        $display("[TB] kill together with wr_done on line 0");
        applyStimulus(36'h0_0000_8000, 3, 0, 2, -1);

        $display("[TB] kill while idle");
        bus.spu_mactl_kill = 1'b1;
        tick();
        bus.spu_mactl_kill = 1'b0;
        checkOutput("idle_kill_busy", 64'(bus.spu_mald_busy), 64'd0);
        applyStimulus(36'h0_0000_9000, 2, -1, 0, -1);

        $display("[TB] async reset during REQ");
        bus.spu_mactl_ldop   = 1'b1;
        bus.spu_mactl_ld_pa  = 36'h0_0000_A000;
        bus.spu_mactl_ld_len = LEN_W'(3);
        tick();
        bus.spu_mactl_ldop = 1'b0;
        checkOutput("pre_rst_ldreq", 64'(bus.spu_mald_ldreq), 64'd1);
        #2 arst_l = 1'b0;
        #1;
        checkOutput("async_rst_ldreq", 64'(bus.spu_mald_ldreq), 64'd0);
        checkOutput("async_rst_busy", 64'(bus.spu_mald_busy), 64'd0);
        checkOutput("async_rst_pa", 64'(bus.spu_mald_pa), 64'd0);
        tick();
        tick();
        #2 arst_l = 1'b1;
        tick();
        checkOutput("post_rst_idle", 64'(bus.spu_mald_busy), 64'd0);
        applyStimulus(36'h0_0000_B000, 3, -1, 0, -1);

        $display("[TB] randomized runs");
        for (int r = 0; r < 10; r++) begin
            rPa   = 36'({$urandom(), $urandom()});
            rLen  = $urandom_range(0, 6);
            rKill = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
            rErr  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : -1;
            applyStimulus(rPa, rLen, rKill, $urandom_range(0, 2), rErr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spu_ma_ldseq.md
# spu_ma_ldseq

Modular-arithmetic (MA) load sequencer for the SPU. It walks a run of 16-byte lines from a start physical address and raises one load request per line toward the LSU. For each line it waits for the load ack and the line-valid indication from `spu_wen`, hands the line to the MA memory writer, then pulses line-reset. After the last line it pulses done. It sits directly upstream of `spu_wen` and drives that block's `spu_mald_ldreq`, `spu_mald_rstln` and `spu_mald_done`.

## Interface
- `LEN_W`, default 8: width of the line-count and line-index fields; maximum run is 2^LEN_W−1 lines.
- `rclk`  in  1  clock; all flops on the rising edge.
- `arst_l`  in  1  reset, asynchronous and active-low; clock is the single clock `rclk`.
- `spu_mactl_ldop`  in  1  start pulse; sampled only in IDLE.
- `spu_mactl_ld_pa`  in  36  start PA[39:4], i.e. the line address; captured on start.
- `spu_mactl_ld_len`  in  LEN_W  number of lines; captured on start.
- `spu_mactl_kill`  in  1  abort request; level or pulse.
- `spu_wen_mald_ack`  in  1  load accepted by the LSU.
- `spu_wen_vld_maln`  in  1  returned line valid.
- `spu_wen_ma_unc_err_pulse`  in  1  uncorrectable L2 error on the returning line.
- `spu_mamem_wr_done`  in  1  MA memory writer has consumed the line.
- `spu_mald_ldreq`  out  1  load request; held until ack.
- `spu_mald_pa`  out  36  PA[39:4] of the current line.
- `spu_mald_line_vld`  out  1  line available to the MA memory writer.
- `spu_mald_line_idx`  out  LEN_W  index of the current line, starting at 0.
- `spu_mald_rstln`  out  1  one-cycle pulse that clears `spu_wen_vld_maln`.
- `spu_mald_done`  out  1  one-cycle completion pulse.
- `spu_mald_busy`  out  1  high in every state except IDLE.
- `spu_mald_err`  out  1  sticky uncorrectable-error flag; cleared on the next accepted start.

## Operation
- **Output decode:** every output is decoded from flops (state register, PA register, index register, remaining-count register, error flag, abort flag). No input reaches an output combinationally.
- **IDLE**
  - `ldop` with `len`≠0: capture PA and len, clear index, error and abort flags, go to REQ.
  - `ldop` with `len`=0: go straight to DONE; no request is issued.
- **REQ:** `ldreq`=1. On `mald_ack`, go to WAIT_DATA. `ldreq` is never withdrawn before the ack.
- **WAIT_DATA:** on `vld_maln`, go to WRITE.
- **WRITE:** `line_vld`=1. On `mamem_wr_done`, go to RSTLN.
- **RSTLN:** `rstln`=1 for one cycle.
  - Update counters: `pa`+=1, modulo 2^36 (wraps silently); `idx`+=1; `remaining`−=1.
  - If `remaining` reaches 0 or the abort flag is set, go to DONE; otherwise go to REQ.
- **DONE:** `done`=1 for one cycle, then return to IDLE.
- **Error capture:** `unc_err_pulse` seen in WAIT_DATA or WRITE sets `err`; the flag stays set until the next accepted start.
- **Kill:**
  - `kill` in any busy state sets the abort flag.
  - The in-flight line always completes: REQ through ack, data return, write, and rstln. This keeps the `spu_wen` valid bit clean.
  - The sequencer then goes to DONE.
  - `kill` in IDLE is ignored.
- **Simultaneous events:**
  - `ldop` while busy is ignored.
  - `kill` together with the final `wr_done` still gives exactly one RSTLN followed by DONE.
  - `ack` together with `kill` in REQ: the ack is honoured and the line completes.

## Timing
- All outputs reset to 0 while `arst_l`=0. State resets to IDLE, PA/index/remaining to 0, both flags to 0.
- Start latency: `ldop` in cycle 0 gives `ldreq`=1 in cycle 1. With `len`=0, `done`=1 in cycle 1.
- `ldreq` falls in the cycle after the ack cycle.
- `spu_wen_vld_maln` rises no earlier than 1 cycle after `spu_wen` sees the return, so the minimum ack→WRITE time is 2 cycles.
- `rstln` is high in cycle N and `spu_wen_vld_maln` clears at the end of N+1. The next WAIT_DATA is entered at N+2 or later, so a stale valid is never seen.
- Per-line minimum: REQ 1, WAIT_DATA 1, WRITE 1, RSTLN 1 = 4 cycles. `done` follows the last RSTLN by 1 cycle.
- Asynchronous reset mid-run drops `ldreq`, `line_vld` and `busy` immediately, without waiting for a clock edge.

## Configuration
- `SPU_MALD_ERR_ABORT_EN`
  - Defined: a captured `unc_err_pulse` also sets the abort flag, so the run ends after the erroring line with `done`=1 and `err`=1.
  - Undefined: the error only sets `err` and the run continues to the full length.

## Test plan
- Start PA=0x000_0010_0, len=3, ack after 2 cycles, wr_done immediate → 3 `ldreq` with `pa` 0x...100, 0x...101, 0x...102; `idx` 0,1,2; 3 `rstln`; one `done`; `busy` falls after `done`.
- len=0 → `done` in cycle 1, no `ldreq`, `busy` high for exactly 1 cycle.
- PA=0xF_FFFF_FFFF, len=2 → second request `pa`=0x0_0000_0000 (wrap), `idx`=1.
- `kill` in WAIT_DATA of line 0 of len=5 → line 0 completes (`rstln` once), then `done`; no second `ldreq`.
- `unc_err_pulse` on line 1 of len=4 → `err`=1. With `SPU_MALD_ERR_ABORT_EN`: 2 `rstln`, then `done`. Without: 4 `rstln`, then `done`. `err` clears on the next `ldop`.
- `arst_l` low while in REQ → `ldreq`=0 asynchronously; after release, state is IDLE and a new start works normally.
